param_data_memory: RTL and testbench
====================================

Name: param_data_memory

Overview:
- Parametrised single-port data memory for the CPU data path; the next generation of the processor's data memory.
- Configurable word width, depth and access latency; adds per-byte write enables, a read-only constant word and synchronous reset.
- Serves one read or one write per transaction over a valid/ready handshake. Sits between the MEM pipeline stage and backing storage.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 4, index bits; DEPTH = 2**ADDR_W words.
- LATENCY, 1, clock edges from acceptance to ready; must be 1..15.
- CONST_ADDR, 1, word index that always reads CONST_VAL.
- CONST_VAL, 1, value returned for reads of CONST_ADDR.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- addr  in  32  word index; bits above ADDR_W-1 must be zero, otherwise the access is out of range.
- wr_data  in  DATA_W  write data.
- be  in  DATA_W/8  byte write enables; bit i covers wr_data[8i+7:8i].
- rw  in  1  1 = write, 0 = read.
- valid  in  1  request; master holds it and all request inputs stable until ready.
- rd_data  out  DATA_W  registered read data.
- ready  out  1  one-cycle completion pulse.
- err  out  1  present only with DMEM_ERR_EN; see Optional Feature.

Behaviour:
- Reset: on rst high at a posedge, state = IDLE, ready = 0, rd_data = 0, err = 0, counter = 0. Memory array contents are not cleared.
- Reset mid-operation: any in-flight transaction is aborted. A pending write is not committed and no ready pulse is issued. valid is ignored while rst is high.

FSM states:
- IDLE: at a posedge with valid = 1, latch addr, rw, wr_data and be (acceptance edge A).
  - LATENCY = 1: go directly to DONE.
  - LATENCY > 1: go to WAIT with counter = LATENCY-2.
- WAIT: counter decrements each edge; at counter = 0, go to DONE.
- DONE: ready = 1 for exactly this cycle, then return to IDLE at the next edge.
  - valid is never sampled in DONE, so a master that still holds valid in the ready cycle is not double-served.
  - A new request can be accepted no earlier than the first IDLE cycle after ready.

Timing and data:
- ready is high in the cycle following edge A+LATENCY-1. LATENCY = 1 gives ready in the cycle immediately after acceptance.
- Read: rd_data is loaded on the edge that enters DONE.
  - Source is mem[addr], or CONST_VAL when addr = CONST_ADDR, or 0 when out of range.
  - rd_data holds its value at all other times, including across writes.
- Write: mem[addr] is updated on the edge that enters DONE, for enabled bytes only; disabled bytes are unchanged.
  - be = 0: completes with ready but changes nothing.
- Writes to CONST_ADDR are dropped; the constant is not writable and ready still pulses.
- Out-of-range access: a write is dropped, a read returns 0, and ready still pulses.
- Request inputs changing after acceptance have no effect: latched copies are used.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - err port exists; err is asserted in the same cycle as ready, for one cycle, when the completed access was out of range or was a write to CONST_ADDR.
  - err = 0 otherwise and after reset.
- Undefined:
  - err port and its logic are absent; such accesses complete silently as described above.

Test Plan:
- LATENCY=1: write mem[3] = 32'hDEADBEEF with be = 4'hF, then read index 3 -> ready one cycle after each acceptance, rd_data = 32'hDEADBEEF.
- Byte enables: mem[5] = 32'h11223344, write 32'hAABBCCDD with be = 4'b0101, read back -> 32'h11BB33DD.
- LATENCY=4: read with valid held high throughout -> ready high exactly in the cycle after edge A+3, one pulse only. Next acceptance is no earlier than the cycle after ready.
- Constant word: write 32'h5 to index 1 (CONST_ADDR), then read index 1 -> 32'h1. With DMEM_ERR_EN, err pulses with ready on the write.
- Out of range (ADDR_W = 4): read addr 32'h10 -> rd_data = 0, ready pulses, err = 1 with DMEM_ERR_EN. Write to 32'h10, then read index 0 -> index 0 unchanged.
- Reset mid-operation (LATENCY = 3): assert rst one cycle after accepting a write of 32'hCAFEF00D to index 7 -> no ready pulse, rd_data = 0, a later read of index 7 returns its prior value.

Source files
------------

// File: rtl/param_data_memory.sv
// Single-port data memory with configurable width, depth and access latency,
// per-byte write enables and a read-only constant word; optional err output under DMEM_ERR_EN.
module param_data_memory #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 4,
    parameter int                LATENCY    = 1,
    parameter int                CONST_ADDR = 1,
    parameter logic [DATA_W-1:0] CONST_VAL  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] be,
    input  logic                rw,
    input  logic                valid,
`ifdef DMEM_ERR_EN
    output logic                err,
`endif
    output logic [DATA_W-1:0]   rd_data,
    output logic                ready
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [31:0]         lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [NB-1:0]       lat_be;
    logic                lat_rw;

    logic [31:0]         req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [NB-1:0]       req_be;
    logic                req_rw;
    logic                enter_done;
    logic                in_range;
    logic                is_const;
    logic                mem_we;
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   read_word;
    logic                acc_err;

    logic [DATA_W-1:0]   mem [DEPTH];

    // With LATENCY = 1 the access completes on the acceptance edge itself,
    // before the latches are loaded, so the live request inputs are used in IDLE.
    always_comb begin
        if (state == IDLE) begin
            req_addr  = addr;
            req_wdata = wr_data;
            req_be    = be;
            req_rw    = rw;
        end else begin
            req_addr  = lat_addr;
            req_wdata = lat_wdata;
            req_be    = lat_be;
            req_rw    = lat_rw;
        end
    end

    assign enter_done = (LATENCY == 1) ? (state == IDLE && valid)
                                       : (state == WAIT && cnt == 4'd0);
    assign in_range   = (req_addr >> ADDR_W) == 32'd0;
    assign is_const   = req_addr == 32'(CONST_ADDR);
    assign idx        = req_addr[ADDR_W-1:0];
    assign mem_we     = enter_done && !rst && req_rw && in_range && !is_const;
    assign acc_err    = !in_range || (req_rw && is_const);
    assign read_word  = is_const ? CONST_VAL : (in_range ? mem[idx] : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ready     <= 1'b0;
            rd_data   <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_rw    <= 1'b0;
`ifdef DMEM_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            ready <= enter_done;
`ifdef DMEM_ERR_EN
            err   <= enter_done && acc_err;
`endif
            if (enter_done && !req_rw)
                rd_data <= read_word;

            case (state)
                IDLE: begin
                    if (valid) begin
                        lat_addr  <= addr;
                        lat_wdata <= wr_data;
                        lat_be    <= be;
                        lat_rw    <= rw;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents survive rst and only
    // the byte lanes selected by be are written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we && req_be[i])
                mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
    end

`ifndef DMEM_ERR_EN
    logic unused_err;
    assign unused_err = acc_err;
`endif

endmodule

// File: tb/tb_param_data_memory.sv
// Directed vector bench for param_data_memory: three instances with LATENCY 1, 4 and 3
// share clk/rst; each has its own request signals.
module tb_param_data_memory;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0][31:0] addr_s;
    logic [2:0][31:0] wdata_s;
    logic [2:0][3:0]  be_s;
    logic [2:0]       rw_s;
    logic [2:0]       valid_s;
    logic [2:0][31:0] rd_s;
    logic [2:0]       ready_s;
`ifdef DMEM_ERR_EN
    logic [2:0]       err_s;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    param_data_memory #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .addr(addr_s[0]), .wr_data(wdata_s[0]), .be(be_s[0]),
        .rw(rw_s[0]), .valid(valid_s[0]),
`ifdef DMEM_ERR_EN
        .err(err_s[0]),
`endif
        .rd_data(rd_s[0]), .ready(ready_s[0]));

    param_data_memory #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .addr(addr_s[1]), .wr_data(wdata_s[1]), .be(be_s[1]),
        .rw(rw_s[1]), .valid(valid_s[1]),
`ifdef DMEM_ERR_EN
        .err(err_s[1]),
`endif
        .rd_data(rd_s[1]), .ready(ready_s[1]));

    param_data_memory #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .addr(addr_s[2]), .wr_data(wdata_s[2]), .be(be_s[2]),
        .rw(rw_s[2]), .valid(valid_s[2]),
`ifdef DMEM_ERR_EN
        .err(err_s[2]),
`endif
        .rd_data(rd_s[2]), .ready(ready_s[2]));

    typedef struct {
        int          k;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        int          lat;
        logic [31:0] rd;
        logic        e;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_err(input int k);
`ifdef DMEM_ERR_EN
        return err_s[k];
`else
        return 1'b0;
`endif
    endfunction

    // One handshake: valid held until ready is seen, then one more edge back to IDLE.
    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int lat, output logic [31:0] rd,
                       output logic e, output logic rdy_after);
        @(negedge clk);
        rw_s[k] = w; addr_s[k] = a; wdata_s[k] = d; be_s[k] = b; valid_s[k] = 1'b1;
        lat = 0; rd = 'x; e = 1'bx;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ready_s[k]) begin
                lat = n; rd = rd_s[k]; e = get_err(k);
                break;
            end
        end
        @(negedge clk);
        valid_s[k] = 1'b0;
        @(posedge clk); #1;
        rdy_after = ready_s[k];
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        logic        ra;
        logic [9:0]  mask;

        rst = 1'b1; addr_s = '0; wdata_s = '0; be_s = '0; rw_s = '0; valid_s = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_ready%0d", k), 32'(ready_s[k]), 32'd0);
            check($sformatf("reset_rd%0d", k), rd_s[k], 32'd0);
`ifdef DMEM_ERR_EN
            check($sformatf("reset_err%0d", k), 32'(err_s[k]), 32'd0);
`endif
        end

        //         k  w     addr          wdata         be     lat rd            err
        vq.push_back('{0, 1'b1, 32'd3,        32'hDEADBEEF, 4'hF,  1, 32'h0,        1'b0});
        vq.push_back('{0, 1'b0, 32'd3,        32'h0,        4'h0,  1, 32'hDEADBEEF, 1'b0});
        vq.push_back('{0, 1'b1, 32'd5,        32'h11223344, 4'hF,  1, 32'hDEADBEEF, 1'b0});
        vq.push_back('{0, 1'b1, 32'd5,        32'hAABBCCDD, 4'h5,  1, 32'hDEADBEEF, 1'b0});
        vq.push_back('{0, 1'b0, 32'd5,        32'h0,        4'h0,  1, 32'h11BB33DD, 1'b0});
        vq.push_back('{0, 1'b1, 32'd1,        32'h5,        4'hF,  1, 32'h11BB33DD, 1'b1});
        vq.push_back('{0, 1'b0, 32'd1,        32'h0,        4'h0,  1, 32'h1,        1'b0});
        vq.push_back('{0, 1'b1, 32'd0,        32'h0000ABCD, 4'hF,  1, 32'h1,        1'b0});
        vq.push_back('{0, 1'b0, 32'h10,       32'h0,        4'h0,  1, 32'h0,        1'b1});
        vq.push_back('{0, 1'b1, 32'h10,       32'hFFFFFFFF, 4'hF,  1, 32'h0,        1'b1});
        vq.push_back('{0, 1'b0, 32'd0,        32'h0,        4'h0,  1, 32'h0000ABCD, 1'b0});
        vq.push_back('{0, 1'b1, 32'd6,        32'hCAFE0000, 4'hF,  1, 32'h0000ABCD, 1'b0});
        vq.push_back('{0, 1'b1, 32'd6,        32'h12345678, 4'h0,  1, 32'h0000ABCD, 1'b0});
        vq.push_back('{0, 1'b0, 32'd6,        32'h0,        4'h0,  1, 32'hCAFE0000, 1'b0});
        vq.push_back('{0, 1'b0, 32'h80000003, 32'h0,        4'h0,  1, 32'h0,        1'b1});
        vq.push_back('{1, 1'b1, 32'd2,        32'h01020304, 4'hF,  4, 32'h0,        1'b0});
        vq.push_back('{1, 1'b0, 32'd2,        32'h0,        4'h0,  4, 32'h01020304, 1'b0});
        vq.push_back('{2, 1'b1, 32'd7,        32'h00000777, 4'hF,  3, 32'h0,        1'b0});
        vq.push_back('{2, 1'b0, 32'd7,        32'h0,        4'h0,  3, 32'h00000777, 1'b0});

        foreach (vq[i]) begin
            txn(vq[i].k, vq[i].w, vq[i].a, vq[i].d, vq[i].b, lat, rd, e, ra);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vq[i].lat));
            check($sformatf("v%0d_rd_data", i), rd, vq[i].rd);
            check($sformatf("v%0d_ready_pulse", i), 32'(ra), 32'd0);
`ifdef DMEM_ERR_EN
            check($sformatf("v%0d_err", i), 32'(e), 32'(vq[i].e));
`endif
        end

        // LATENCY=4 with valid held high: ready at samples 4 and 9 only.
        @(negedge clk);
        rw_s[1] = 1'b0; addr_s[1] = 32'd2; valid_s[1] = 1'b1;
        mask = '0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            mask[n] = ready_s[1];
        end
        @(negedge clk); valid_s[1] = 1'b0;
        check("l4_held_valid_ready_mask", 32'(mask), 32'h108);
        check("l4_held_valid_rd", rd_s[1], 32'h01020304);

        // Request inputs changing after acceptance must not affect the access.
        @(negedge clk);
        rw_s[1] = 1'b1; addr_s[1] = 32'd2; wdata_s[1] = 32'hAAAA5555; be_s[1] = 4'hF; valid_s[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        rw_s[1] = 1'b0; addr_s[1] = 32'd3; wdata_s[1] = 32'h0; be_s[1] = 4'h0;
        lat = 0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ready_s[1]) begin lat = n; break; end
        end
        check("latched_req_latency", 32'(lat), 32'd4);
        check("latched_req_rd_held", rd_s[1], 32'h01020304);
        @(negedge clk); valid_s[1] = 1'b0;
        @(posedge clk);
        txn(1, 1'b0, 32'd2, 32'h0, 4'h0, lat, rd, e, ra);
        check("latched_req_readback", rd, 32'hAAAA5555);

        // Reset one cycle after accepting a write on the LATENCY=3 instance.
        @(negedge clk);
        rw_s[2] = 1'b1; addr_s[2] = 32'd7; wdata_s[2] = 32'hCAFEF00D; be_s[2] = 4'hF; valid_s[2] = 1'b1;
        @(posedge clk); #1;
        mask = '0;
        mask[0] = ready_s[2];
        @(negedge clk); rst = 1'b1; valid_s[2] = 1'b0;
        @(posedge clk); #1;
        mask[1] = ready_s[2];
        @(negedge clk); rst = 1'b0;
        for (int n = 2; n < 8; n++) begin
            @(posedge clk); #1;
            mask[n] = ready_s[2];
        end
        check("rst_mid_no_ready", 32'(mask), 32'd0);
        check("rst_mid_rd_cleared", rd_s[2], 32'd0);
        txn(2, 1'b0, 32'd7, 32'h0, 4'h0, lat, rd, e, ra);
        check("rst_mid_latency", 32'(lat), 32'd3);
        check("rst_mid_prior_value", rd, 32'h00000777);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
